// File: rtl/dense_pkg.sv
// dense_pkg: shared types and constants for the dense-matrix operand feeder.
//   feeder_state_t : feeder FSM states (IDLE, PRIME, STREAM)
//   N_DEF, DW_DEF  : default matrix dimension and element width
//   beats_total(n) : beats in one full stream, (n/2)*n*(n+1)
package dense_pkg;

    localparam int N_DEF  = 560;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } feeder_state_t;

    function automatic int beats_total(input int n);
        return (n / 2) * n * (n + 1);
    endfunction

endpackage

// File: rtl/dense_feeder_if.sv
// dense_feeder_if: control, RAM and multiplier-side signals of dense_feeder.
//   master modport : the feeder (drives busy/done, RAM reads, mm_rst, datain*)
//   slave modport  : the environment (drives start and both RAM read-data buses)
interface dense_feeder_if
    import dense_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = $clog2(N_DEF * N_DEF / 2)
);
    logic          start;
    logic          busy;
    logic          done;
    logic          a_rd;
    logic [AW-1:0] a_addr;
    logic [2*DW-1:0] a_rdata;
    logic          b_rd;
    logic [AW-1:0] b_addr;
    logic [2*DW-1:0] b_rdata;
    logic          mm_rst;
    logic [DW-1:0] datain1;
    logic [DW-1:0] datain2;

    modport master (
        input  start, a_rdata, b_rdata,
        output busy, done, a_rd, a_addr, b_rd, b_addr, mm_rst, datain1, datain2
    );

    modport slave (
        output start, a_rdata, b_rdata,
        input  busy, done, a_rd, a_addr, b_rd, b_addr, mm_rst, datain1, datain2
    );
endinterface

// File: rtl/dense_addr_gen.sv
// dense_addr_gen: read-address sequencer for the A and B pair-word RAMs.
//   clk, rst   : clock, synchronous active-low reset
//   step       : a read is issued this cycle; advance to the next beat
//   clear      : restart from beat 0 (accepted start)
//   a_rd/b_rd  : read enables (exactly one high while step is high)
//   a_addr/b_addr : word addresses, driven straight from the counters
//   last       : every beat of the stream has been issued
module dense_addr_gen
    import dense_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = $clog2(N * N / 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic          clear,
    output logic          a_rd,
    output logic          b_rd,
    output logic [AW-1:0] a_addr,
    output logic [AW-1:0] b_addr,
    output logic          last
);
    localparam int PW = $clog2(N + 1);
    localparam logic [AW-1:0] WMAX = AW'(N * N / 2 - 1);
    localparam logic [PW-1:0] PMAX = PW'(N);

    // phase 0 = A beat, phases 1..N = B beats of the current segment
    logic [PW-1:0] phase_q, phase_d;
    logic [AW-1:0] a_q, a_d, b_q, b_d;
    logic          last_q, last_d;
    logic          seg_end;

    always_comb begin
        seg_end = (phase_q == PMAX);
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        last_d  = last_q;
        if (clear) begin
            phase_d = '0;
            a_d     = '0;
            b_d     = '0;
            last_d  = 1'b0;
        end else if (step) begin
            phase_d = seg_end ? '0 : phase_q + 1'b1;
            if (phase_q != '0)
                b_d = (b_q == WMAX) ? '0 : b_q + 1'b1;
            // a_addr holds on the final segment so it never wraps inside a run
            if (seg_end) begin
                if (a_q == WMAX) last_d = 1'b1;
                else             a_d    = a_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            last_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            last_q  <= last_d;
        end
    end

    assign a_rd   = step && (phase_q == '0);
    assign b_rd   = step && (phase_q != '0);
    assign a_addr = a_q;
    assign b_addr = b_q;
    assign last   = last_q;
endmodule

// File: rtl/dense_feeder.sv
// dense_feeder: streams A pairs and B row pairs into the dense multiplier,
// one beat per cycle, and owns the multiplier's active-low reset.
//   clk, rst : clock, synchronous active-low reset
//   bus      : dense_feeder_if.master (start/busy/done, A and B RAM read
//              ports, mm_rst, datain1/datain2)
//   beat_cnt : beats driven in the current/last run; only present when
//              DENSE_FEEDER_BEAT_CNT_EN is defined
module dense_feeder
    import dense_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = $clog2(N * N / 2)
) (
    input  logic clk,
    input  logic rst,
    dense_feeder_if.master bus
`ifdef DENSE_FEEDER_BEAT_CNT_EN
    ,
    output logic [31:0] beat_cnt
`endif
);
    feeder_state_t   state_q, state_d;
    logic            accept, step, last, busy;
    logic            a_rd, b_rd;
    logic [AW-1:0]   a_addr, b_addr;
    logic            rvld_q, rsel_a_q, done_q, mm_rst_q;
    logic [DW-1:0]   d1_q, d2_q;
    logic [2*DW-1:0] rdata;

    assign accept = (state_q == IDLE) && bus.start;

    dense_addr_gen #(.N(N), .AW(AW)) u_addr (
        .clk    (clk),
        .rst    (rst),
        .step   (step),
        .clear  (accept),
        .a_rd   (a_rd),
        .b_rd   (b_rd),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .last   (last)
    );

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // STREAM ends once everything is issued and the RAM stage is empty,
    // i.e. while the last beat sits on datain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = PRIME;
            PRIME:   state_d = STREAM;
            STREAM:  if (last && !rvld_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        step = 1'b0;
        unique case (state_q)
            PRIME:  begin busy = 1'b1; step = 1'b1;  end
            STREAM: begin busy = 1'b1; step = !last; end
            default: ;
        endcase
    end

    assign rdata = rsel_a_q ? bus.a_rdata : bus.b_rdata;

    // rvld_q marks RAM data arriving this cycle; it becomes a beat next edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rvld_q   <= 1'b0;
            rsel_a_q <= 1'b0;
            done_q   <= 1'b0;
            mm_rst_q <= 1'b0;
            d1_q     <= '0;
            d2_q     <= '0;
        end else begin
            rvld_q   <= a_rd | b_rd;
            rsel_a_q <= a_rd;
            done_q   <= (state_q == STREAM) && (state_d == IDLE);
            // held low through PRIME so the multiplier counts from beat 0
            if (accept)                mm_rst_q <= 1'b0;
            else if (state_q == PRIME) mm_rst_q <= 1'b1;
            d1_q     <= rvld_q ? rdata[DW-1:0]    : '0;
            d2_q     <= rvld_q ? rdata[2*DW-1:DW] : '0;
        end
    end

`ifdef DENSE_FEEDER_BEAT_CNT_EN
    logic [31:0] beat_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst)        beat_cnt_q <= '0;
        else if (accept) beat_cnt_q <= '0;
        else if (rvld_q) beat_cnt_q <= beat_cnt_q + 32'd1;
    end
    assign beat_cnt = beat_cnt_q;
`endif

    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.a_rd    = a_rd;
    assign bus.a_addr  = a_addr;
    assign bus.b_rd    = b_rd;
    assign bus.b_addr  = b_addr;
    assign bus.mm_rst  = mm_rst_q;
    assign bus.datain1 = d1_q;
    assign bus.datain2 = d2_q;
endmodule

// File: tb/tb_dense_feeder.sv
// tb_dense_feeder: self-checking bench for dense_feeder with N=4, DW=32.
// Honours DENSE_FEEDER_BEAT_CNT_EN when defined.
module tb_dense_feeder;
    import dense_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = $clog2(N * N / 2);
    localparam int T  = beats_total(N);

    logic clk;
    logic rst;
    int   n_err = 0;
    int   n_chk = 0;

    dense_feeder_if #(.DW(DW), .AW(AW)) bus ();

`ifdef DENSE_FEEDER_BEAT_CNT_EN
    logic [31:0] beat_cnt;
`endif

    dense_feeder #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef DENSE_FEEDER_BEAT_CNT_EN
        ,
        .beat_cnt (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: A word w = {w+100, w}, B word w = {w+200, w}, 1-cycle latency
    always @(posedge clk) begin
        if (bus.a_rd) bus.a_rdata <= {32'(bus.a_addr) + 32'd100, 32'(bus.a_addr)};
        if (bus.b_rd) bus.b_rdata <= {32'(bus.b_addr) + 32'd200, 32'(bus.b_addr)};
    end

    // reference stream: per beat, which RAM, which word, expected {datain1,datain2}
    bit          exp_isa [0:T-1];
    int          exp_w   [0:T-1];
    logic [63:0] exp_d   [0:T-1];

    task automatic build_model();
        int n = 0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k += 2) begin
                exp_isa[n] = 1'b1;
                exp_w[n]   = i * (N / 2) + k / 2;
                exp_d[n]   = {32'(exp_w[n]), 32'(exp_w[n] + 100)};
                n++;
                for (int r = k; r <= k + 1; r++)
                    for (int c = 0; c < N; c += 2) begin
                        exp_isa[n] = 1'b0;
                        exp_w[n]   = r * (N / 2) + c / 2;
                        exp_d[n]   = {32'(exp_w[n]), 32'(exp_w[n] + 200)};
                        n++;
                    end
            end
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] all_out();
        return {bus.busy, bus.done, bus.a_rd, bus.b_rd, bus.mm_rst,
                bus.a_addr, bus.b_addr, bus.datain1, bus.datain2};
    endfunction

    function automatic logic [7:0] issue_got();
        return {bus.a_rd, bus.b_rd, bus.a_rd ? bus.a_addr : 3'd0,
                bus.b_rd ? bus.b_addr : 3'd0};
    endfunction

    function automatic logic [7:0] issue_exp(input int c);
        logic [2:0] w;
        if (c >= T) return 8'd0;
        w = 3'(exp_w[c]);
        return {exp_isa[c], !exp_isa[c], exp_isa[c] ? w : 3'd0, exp_isa[c] ? 3'd0 : w};
    endfunction

    // Caller raises start before the sampling edge E0. Cycle c is the cycle
    // after edge E0+c: read c is issued there and beat c-2 is on datain.
    task automatic run(input int hold, input bit chain, input int abort_at);
        for (int c = 0; c <= T + 1; c++) begin
            tick();
            if (c == 0) begin
                chk("prime_ctl", {bus.busy, bus.mm_rst, bus.done}, 3'b100);
`ifdef DENSE_FEEDER_BEAT_CNT_EN
                chk("cnt_start", beat_cnt, 0);
`endif
            end else begin
                chk("run_ctl", {bus.busy, bus.mm_rst, bus.done}, 3'b110);
            end
            chk("issue", issue_got(), issue_exp(c));
            chk("beat", {bus.datain1, bus.datain2}, (c >= 2) ? exp_d[c-2] : 64'd0);
            bus.start = (c < hold - 1);
            if (abort_at >= 0 && c == abort_at + 2) begin
                rst       = 1'b0;
                bus.start = 1'b0;
                tick();
                chk("abort_state", all_out(), 0);
`ifdef DENSE_FEEDER_BEAT_CNT_EN
                chk("abort_cnt", beat_cnt, 0);
`endif
                rst = 1'b1;
                return;
            end
        end
        tick();
        chk("done_ctl", {bus.busy, bus.done, bus.mm_rst}, 3'b011);
        chk("done_data", {bus.datain1, bus.datain2, issue_got()}, 0);
`ifdef DENSE_FEEDER_BEAT_CNT_EN
        chk("cnt_done", beat_cnt, T);
`endif
        bus.start = chain;
        if (!chain) begin
            tick();
            chk("after_done", {bus.busy, bus.done, bus.mm_rst}, 3'b001);
        end
    endtask

    initial begin
        bit chained;
        build_model();
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (3) tick();
        chk("reset_state", all_out(), 0);
`ifdef DENSE_FEEDER_BEAT_CNT_EN
        chk("reset_cnt", beat_cnt, 0);
`endif
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle", all_out(), 0);
        end

        // single run
        bus.start = 1'b1;
        run(1, 1'b0, -1);
        repeat ($urandom_range(0, 3)) tick();

        // start held while busy
        bus.start = 1'b1;
        run(5, 1'b0, -1);

        // back-to-back via start in the done cycle
        bus.start = 1'b1;
        run(1, 1'b1, -1);
        run($urandom_range(1, 4), 1'b0, -1);

        // abort at beat 17, then a clean restart from A0
        bus.start = 1'b1;
        run(1, 1'b0, 17);
        repeat (2) tick();
        bus.start = 1'b1;
        run(1, 1'b0, -1);

        // randomized gaps, start hold lengths, aborts and chaining
        chained = 1'b0;
        for (int it = 0; it < 6; it++) begin
            int hold, abort_at;
            if (!chained) begin
                repeat ($urandom_range(0, 4)) tick();
                bus.start = 1'b1;
            end
            hold     = $urandom_range(1, 6);
            abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, T - 1)) : -1;
            chained  = (abort_at < 0) && ($urandom_range(0, 1) == 1);
            run(hold, chained, abort_at);
        end
        if (chained) run(1, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/dense_feeder.md
# dense_feeder

Streams operands into the dense-dense matrix multiplier. It reads matrices A and B from two single-port synchronous RAMs and emits the interleaved beat sequence the multiplier consumes: one A pair, then two full B rows, repeated for every row of A. It also owns the multiplier's active-low reset, so the multiplier's beat count starts exactly on beat 0. The multiplier applies no backpressure, so the feeder emits one beat every cycle from first beat to last.

## Interface
Parameters:
- N, 560, matrix dimension; must be even and ≥ 2.
- DW, 32, element width.
- AW, $clog2(N*N/2), RAM word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; honoured only in IDLE.
- busy  out  1  high in PRIME and STREAM.
- done  out  1  one-cycle pulse after the last beat.
- a_rd  out  1  A RAM read enable.
- a_addr  out  AW  A word address.
- a_rdata  in  2*DW  A word; [DW-1:0] = even column, [2DW-1:DW] = odd column; 1-cycle read latency.
- b_rd, b_addr, b_rdata: same as the A ports, for the B RAM.
- mm_rst  out  1  multiplier reset, active-low.
- datain1  out  DW  even-column element of the current beat.
- datain2  out  DW  odd-column element of the current beat.

## Operation
- RAM layout: row-major pair-words. The word for (r, c) with c even is at r*(N/2)+c/2.
- Stream order:
  - For row i = 0..N-1 and k = 0..N-2 step 2: one A beat carrying (A[i][k], A[i][k+1]), then N B beats covering rows k and k+1 of B, two elements per beat.
  - A segment is N+1 beats. Total beats T = (N/2)·N·(N+1).
- Address generation needs only two linear counters:
  - a_addr increments once per segment, over 0..N*N/2-1.
  - b_addr increments every B beat and wraps from N*N/2-1 to 0.
  - A phase counter 0..N selects A (phase 0) or B (phases 1..N).
- FSM:
  - IDLE: start → PRIME.
  - PRIME: lasts 1 cycle; issues the read for beat 0; → STREAM.
  - STREAM: issues one read per cycle until beat T-1 has been issued, then runs 2 more cycles to drain the pipeline; → IDLE with a done pulse.
- Exactly one of a_rd / b_rd is high per issuing cycle. Both are low in IDLE and in the drain cycles.
- mm_rst:
  - Reset value 0.
  - Driven 0 during PRIME.
  - Rises at the end of PRIME and stays 1 through STREAM and afterwards, so the multiplier can drain its results.
  - Falls again only on the next start, or on rst.
- datain1/datain2 are 0 whenever no beat is present.
- start while busy is ignored. start coinciding with done is accepted, giving back-to-back runs.

## Timing
- Reset values: busy=0, done=0, a_rd=0, b_rd=0, a_addr=0, b_addr=0, mm_rst=0, datain1=0, datain2=0, FSM state IDLE.
- start is sampled at edge E0. PRIME occupies cycle E0–E1 and drives a_rd=1, a_addr=0.
- mm_rst goes high from E1.
- Beat 0 is registered at E2, i.e. one cycle after mm_rst rises.
- Beat j occupies cycle E2+j to E2+j+1. Beats are contiguous, with no gaps.
- A read issued in cycle c appears on datain in cycle c+2. The address registers drive directly into the RAM.
- The last beat (T-1) is held for one cycle. On the following edge: datain returns to 0, done pulses for one cycle, busy drops, state → IDLE.
- rst low mid-run: at the next edge all outputs take their reset values and the stream aborts. This includes mm_rst=0, which resets the multiplier.
- Counter wrap: b_addr wraps exactly at the end of B row N-1. a_addr never wraps within a run.

## Configuration
- DENSE_FEEDER_BEAT_CNT_EN defined: adds output beat_cnt [31:0].
  - Reset to 0 and cleared on an accepted start.
  - Increments on every beat driven.
  - Holds T after done until the next start.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

## Structure
- Package dense_pkg holds:
  - typedef feeder_state_t {IDLE, PRIME, STREAM}.
  - Default constants N_DEF=560 and DW_DEF=32.
  - Function beats_total(n), returning (n/2)·n·(n+1).
- Sub-module dense_addr_gen (parameters N, AW):
  - Contains the phase counter, a_addr/b_addr counters, a_rd/b_rd generation and the last-issue flag.
  - Inputs: clk, rst, step, clear.
- dense_feeder holds the FSM, mm_rst and the output data registers.

## Test plan
Benches use N=4, DW=32, T=40. The A RAM holds A word w = {w+100, w}; the B RAM holds B word w = {w+200, w}.

- Reset then idle 10 cycles: every output is 0 and no read is issued.
- Single start:
  - mm_rst rises 1 cycle after start and beat 0 follows one cycle later.
  - The word order on datain is A0, B0, B1, B2, B3, A1, B4, B5, B6, B7, A2, B0, …, A7, B4…B7.
  - Beat 0: datain1=0, datain2=100. Beat 1: datain1=0, datain2=200.
  - Exactly 40 contiguous beats, then done for 1 cycle and datain back to 0.
- start held high for 5 cycles while busy: no restart, and the beat order is unchanged.
- start pulsed in the done cycle: mm_rst drops for 1 cycle and the second run repeats an identical 40-beat stream.
- rst low at beat 17: on the next edge every output equals its reset value, and a later start begins again from A0.
- With DENSE_FEEDER_BEAT_CNT_EN: beat_cnt reads 40 after done, and 0 right after a new start.
